// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Posted-write buffer between the core data port and data memory. Each store
//   is captured into a DEPTH-entry FIFO in one cycle. Entries drain in order
//   over a valid/ready write channel. Load data returns to the core
//   combinationally.
//
//   Optional feature macro: STORE_FWD_EN
//     defined   : loads that hit a buffered word get the youngest matching data
//     undefined : ReadData is always MemRData
//
// Ports
//   clk        core clock, rising edge
//   reset      asynchronous, active-low reset
//   MemWrite   store strobe, one store per asserted cycle
//   ALUResult  byte address for loads and stores
//   WriteData  store data
//   ReadData   load data to core (combinational)
//   MemRData   data memory read data at ALUResult
//   wr_valid   head entry available on the write channel
//   wr_addr    head entry word address, bits [1:0] are zero
//   wr_data    head entry data
//   wr_ready   memory accepts the head entry this cycle
//   Count      entries held
//   Full       Count == DEPTH
//   Empty      Count == 0
//   Overflow   sticky, set when a store was dropped
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MemWrite,
  input  logic [AW-1:0]                ALUResult,
  input  logic [DW-1:0]                WriteData,
  output logic [DW-1:0]                ReadData,
  input  logic [DW-1:0]                MemRData,
  output logic                         wr_valid,
  output logic [AW-1:0]                wr_addr,
  output logic [DW-1:0]                wr_data,
  input  logic                         wr_ready,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Full,
  output logic                         Empty,
  output logic                         Overflow
);

  // state   | meaning
  // EMPTY   | no entries held, wr_valid low
  // PARTIAL | 1..DEPTH-1 entries held
  // FULL    | DEPTH entries held, new stores are dropped
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            enq, deq;

  logic [AW-3:0]   addr_q [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];

  // Byte-offset bits never take part in storage or matching.
  logic            unused_addr_lsbs;
  assign unused_addr_lsbs = ^ALUResult[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    Full     = (state_q == FULL);
    Empty    = (state_q == EMPTY);
    wr_valid = (state_q != EMPTY);
    // A store arriving while FULL is dropped even if the head drains this cycle.
    enq      = MemWrite && (state_q != FULL);
    deq      = (state_q != EMPTY) && wr_ready;

    if (MemWrite && (state_q == FULL)) ovf_d = 1'b1;
    if (enq) tail_d = tail_q + 1'b1;
    if (deq) head_d = head_q + 1'b1;
    if (enq && !deq) count_d = count_q + 1'b1;
    if (deq && !enq) count_d = count_q - 1'b1;

    case (state_q)
      EMPTY:   if (enq) state_d = PARTIAL;
      PARTIAL: begin
        if (enq && !deq && (count_q == CW'(DEPTH-1))) state_d = FULL;
        if (deq && !enq && (count_q == CW'(1)))       state_d = EMPTY;
      end
      FULL:    if (deq) state_d = PARTIAL;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= ALUResult[AW-1:2];
      data_q[tail_q] <= WriteData;
    end
  end

  assign wr_addr  = {addr_q[head_q], 2'b00};
  assign wr_data  = data_q[head_q];
  assign Count    = count_q;
  assign Overflow = ovf_q;

`ifdef STORE_FWD_EN
  // Walk from oldest to youngest so the youngest match wins. The head entry
  // still forwards in the cycle it is accepted by memory.
  always_comb begin
    ReadData = MemRData;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) &&
          (addr_q[head_q + PW'(i)] == ALUResult[AW-1:2]))
        ReadData = data_q[head_q + PW'(i)];
    end
  end
`else
  assign ReadData = MemRData;
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] MemRData;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [2:0]  Count;
  logic        Full;
  logic        Empty;
  logic        Overflow;

  int n_checks = 0;
  int n_fail   = 0;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData), .MemRData(MemRData),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .Count(Count), .Full(Full), .Empty(Empty),
    .Overflow(Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; MemWrite = 1'b0; ALUResult = '0; WriteData = '0;
    MemRData = '0; wr_ready = 1'b0;
    #1;
    n_checks++; if (Count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", Count); end
    n_checks++; if (Empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", Empty); end
    n_checks++; if (Full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", Full); end
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", Overflow); end
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_fill_hold();
    MemWrite = 1'b1; ALUResult = 32'h10; WriteData = 32'hAAAA_0001;
    #1;
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL enq_latency: wr_valid got %b want 0", wr_valid); end
    tick();
    n_checks++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", wr_valid); end
    ALUResult = 32'h14; WriteData = 32'hBBBB_0002; tick();
    ALUResult = 32'h18; WriteData = 32'hCCCC_0003; tick();
    MemWrite = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (Count !== 3'd3) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want 3", k, Count); end
      n_checks++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid[%0d]: got %b want 1", k, wr_valid); end
      n_checks++; if (wr_addr !== 32'h10) begin n_fail++; $display("FAIL hold_addr[%0d]: got %h want 00000010", k, wr_addr); end
      n_checks++; if (wr_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL hold_data[%0d]: got %h want aaaa0001", k, wr_data); end
      tick();
    end
  endtask

  task automatic test_drain();
    logic [31:0] ea [3];
    logic [31:0] ed [3];
    ea = '{32'h10, 32'h14, 32'h18};
    ed = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    wr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (wr_addr !== ea[k]) begin n_fail++; $display("FAIL drain_addr[%0d]: got %h want %h", k, wr_addr, ea[k]); end
      n_checks++; if (wr_data !== ed[k]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", k, wr_data, ed[k]); end
      tick();
    end
    n_checks++; if (Empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", Empty); end
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", wr_valid); end
    n_checks++; if (Count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", Count); end
    wr_ready = 1'b0;
  endtask

  task automatic test_overflow();
    // 0x31 checks that the byte offset is cleared on the write channel.
    logic [31:0] sa [4];
    sa = '{32'h31, 32'h34, 32'h38, 32'h3C};
    MemWrite = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ALUResult = sa[k]; WriteData = 32'hD000_0000 + k; tick();
    end
    n_checks++; if (Full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b want 1", Full); end
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", Overflow); end
    ALUResult = 32'h40; WriteData = 32'hBAD0_0040; tick();
    MemWrite = 1'b0;
    n_checks++; if (Full !== 1'b1) begin n_fail++; $display("FAIL full_after_drop: got %b want 1", Full); end
    n_checks++; if (Count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", Count); end
    n_checks++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", Overflow); end
    n_checks++; if (wr_addr !== 32'h30) begin n_fail++; $display("FAIL full_head_addr: got %h want 00000030", wr_addr); end
  endtask

  task automatic test_full_store_with_deq();
    logic [31:0] ea [3];
    ea = '{32'h34, 32'h38, 32'h3C};
    MemWrite = 1'b1; ALUResult = 32'h50; WriteData = 32'hBAD0_0050; wr_ready = 1'b1;
    tick();
    MemWrite = 1'b0; wr_ready = 1'b0;
    n_checks++; if (Count !== 3'd3) begin n_fail++; $display("FAIL full_deq_count: got %0d want 3", Count); end
    n_checks++; if (Full !== 1'b0) begin n_fail++; $display("FAIL full_deq_full: got %b want 0", Full); end
    n_checks++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", Overflow); end
    wr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (wr_addr !== ea[k]) begin n_fail++; $display("FAIL ovf_drain_addr[%0d]: got %h want %h", k, wr_addr, ea[k]); end
      n_checks++; if (wr_data !== 32'hD000_0001 + k) begin n_fail++; $display("FAIL ovf_drain_data[%0d]: got %h want %h", k, wr_data, 32'hD000_0001 + k); end
      tick();
    end
    n_checks++; if (Empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_empty: got %b want 1", Empty); end
    wr_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    MemWrite = 1'b1; ALUResult = 32'h60; WriteData = 32'h0000_0600; tick();
    ALUResult = 32'h64; WriteData = 32'h0000_0640; wr_ready = 1'b1;
    #1;
    n_checks++; if (wr_addr !== 32'h60) begin n_fail++; $display("FAIL b2b_head0: got %h want 00000060", wr_addr); end
    tick();
    MemWrite = 1'b0;
    n_checks++; if (Count !== 3'd1) begin n_fail++; $display("FAIL b2b_count: got %0d want 1", Count); end
    n_checks++; if (wr_addr !== 32'h64) begin n_fail++; $display("FAIL b2b_head1_addr: got %h want 00000064", wr_addr); end
    n_checks++; if (wr_data !== 32'h0000_0640) begin n_fail++; $display("FAIL b2b_head1_data: got %h want 00000640", wr_data); end
    tick();
    wr_ready = 1'b0;
    n_checks++; if (Empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b want 1", Empty); end
  endtask

  task automatic test_forward();
    logic [31:0] exp_hit;
`ifdef STORE_FWD_EN
    exp_hit = 32'h22;
`else
    exp_hit = 32'hDEAD;
`endif
    MemWrite = 1'b1; ALUResult = 32'h20; WriteData = 32'h11; tick();
    WriteData = 32'h22; tick();
    MemWrite = 1'b0; ALUResult = 32'h21; MemRData = 32'hDEAD;
    #1;
    n_checks++; if (ReadData !== exp_hit) begin n_fail++; $display("FAIL fwd_hit: got %h want %h", ReadData, exp_hit); end
    ALUResult = 32'h24;
    #1;
    n_checks++; if (ReadData !== 32'hDEAD) begin n_fail++; $display("FAIL fwd_miss: got %h want 0000dead", ReadData); end
    n_checks++; if (Count !== 3'd2) begin n_fail++; $display("FAIL fwd_count: got %0d want 2", Count); end
  endtask

  task automatic test_async_reset();
    n_checks++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL prereset_valid: got %b want 1", wr_valid); end
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", wr_valid); end
    n_checks++; if (Count !== 3'd0) begin n_fail++; $display("FAIL arst_count: got %0d want 0", Count); end
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL arst_ovf: got %b want 0", Overflow); end
    #1;
    reset = 1'b1;
    wr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid[%0d]: got %b want 0", k, wr_valid); end
      n_checks++; if (Empty !== 1'b1) begin n_fail++; $display("FAIL post_rst_empty[%0d]: got %b want 1", k, Empty); end
    end
    wr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_hold();
    test_drain();
    test_overflow();
    test_full_store_with_deq();
    test_back_to_back();
    test_forward();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
